// File: rtl/result_bus_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// result_bus_scheduler_pkg
// Shared definitions for the result bus scheduler and its rotating picker:
//   - flat-array slice macro (slice i of width w out of a packed vector)
//   - default station/bus counts and the matching index width
//   - index_add_mod(): (a + b) mod n for station indices, done as
//     compare-and-subtract so it also works for non-power-of-2 counts.
// No ports; imported with result_bus_scheduler_pkg::*.
// -----------------------------------------------------------------------------
`define RBS_SLICE(vec, i, w) vec[(i)*(w) +: (w)]

package result_bus_scheduler_pkg;

   localparam int STATION_COUNT_DEFAULT      = 4;
   localparam int BUS_COUNT_DEFAULT          = 2;
   localparam int STATION_INDEX_SIZE_DEFAULT = $clog2(STATION_COUNT_DEFAULT);

   // Operands are always below n, so a single conditional subtract wraps.
   function automatic int unsigned index_add_mod(input int unsigned a,
                                                 input int unsigned b,
                                                 input int unsigned n);
      int unsigned sum;
      sum = a + b;
      if (sum >= n) begin
         sum = sum - n;
      end else begin
         sum = sum;
      end
      return sum;
   endfunction

endpackage

// File: rtl/result_bus_scheduler_picker.sv
// -----------------------------------------------------------------------------
// rotating_priority_picker
// Purely combinational round-robin allocator. Stations are scanned starting
// at i_ptr and wrapping; each requesting station takes the lowest-index free
// bus that is still untaken this cycle. At most one bus per station.
// Ports:
//   i_request    per-station request vector
//   i_ptr        scan start index
//   i_bus_free   per-bus availability mask
//   o_grant      per-station grant vector
//   o_bus_source flat per-bus station index (valid where o_bus_taken is set)
//   o_bus_taken  per-bus "allocated this cycle" flags
//   o_next_ptr   one past the last station granted in scan order, else i_ptr
// -----------------------------------------------------------------------------
module rotating_priority_picker
   import result_bus_scheduler_pkg::*;
#(
   parameter int STATION_COUNT      = STATION_COUNT_DEFAULT,
   parameter int BUS_COUNT          = BUS_COUNT_DEFAULT,
   parameter int STATION_INDEX_SIZE = STATION_INDEX_SIZE_DEFAULT
) (
   input  logic [STATION_COUNT-1:0]                i_request,
   input  logic [STATION_INDEX_SIZE-1:0]           i_ptr,
   input  logic [BUS_COUNT-1:0]                    i_bus_free,
   output logic [STATION_COUNT-1:0]                o_grant,
   output logic [STATION_INDEX_SIZE*BUS_COUNT-1:0] o_bus_source,
   output logic [BUS_COUNT-1:0]                    o_bus_taken,
   output logic [STATION_INDEX_SIZE-1:0]           o_next_ptr
);

   logic [STATION_INDEX_SIZE-1:0] w_idx;
   logic                          w_placed;

   // Scan stations in rotating order and hand out buses lowest-index first.
   always_comb begin
      o_grant      = '0;
      o_bus_source = '0;
      o_bus_taken  = '0;
      o_next_ptr   = i_ptr;
      w_idx        = '0;
      w_placed     = 1'b0;
      for (int k = 0; k < STATION_COUNT; k++) begin
         w_idx    = STATION_INDEX_SIZE'(index_add_mod(32'(i_ptr), k, STATION_COUNT));
         w_placed = 1'b0;
         for (int j = 0; j < BUS_COUNT; j++) begin
            if (i_request[w_idx] && !w_placed && i_bus_free[j] && !o_bus_taken[j]) begin
               w_placed                                     = 1'b1;
               o_bus_taken[j]                               = 1'b1;
               o_grant[w_idx]                               = 1'b1;
               `RBS_SLICE(o_bus_source, j, STATION_INDEX_SIZE) = w_idx;
               // Later grants in scan order overwrite, leaving one past the last.
               o_next_ptr = STATION_INDEX_SIZE'(index_add_mod(32'(w_idx), 1, STATION_COUNT));
            end else begin
               w_placed = w_placed;
            end
         end
      end
   end

endmodule

// File: rtl/result_bus_scheduler.sv
// -----------------------------------------------------------------------------
// result_bus_scheduler
// Registered round-robin scheduler for the common result buses. Up to
// BUS_COUNT ready stations are granted per cycle (combinational grant); the
// granted values appear on the per-bus output registers on the next cycle.
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   flush             empties all buses, suppresses grants, keeps the pointer
//   station_ready     per-station result-present flags
//   station_value     flat array of station results (slice i = station i)
//   station_grant     combinational per-station accept
//   bus_hold          per-bus consumer stall (only meaningful on a valid bus)
//   bus_asserted      registered per-bus valid
//   bus_source        registered flat per-bus station index
//   bus_value         registered flat per-bus value
// -----------------------------------------------------------------------------
module result_bus_scheduler
   import result_bus_scheduler_pkg::*;
#(
   parameter int SIZE               = 32,
   parameter int STATION_COUNT      = STATION_COUNT_DEFAULT,
   parameter int BUS_COUNT          = BUS_COUNT_DEFAULT,
   parameter int STATION_INDEX_SIZE = $clog2(STATION_COUNT)
) (
   input  logic                                    clock,
   input  logic                                    reset,
   input  logic                                    flush,
   input  logic [STATION_COUNT-1:0]                station_ready,
   input  logic [SIZE*STATION_COUNT-1:0]           station_value,
   output logic [STATION_COUNT-1:0]                station_grant,
   input  logic [BUS_COUNT-1:0]                    bus_hold,
   output logic [BUS_COUNT-1:0]                    bus_asserted,
   output logic [STATION_INDEX_SIZE*BUS_COUNT-1:0] bus_source,
   output logic [SIZE*BUS_COUNT-1:0]               bus_value
);

   logic [BUS_COUNT-1:0]                    r_bus_asserted;
   logic [STATION_INDEX_SIZE*BUS_COUNT-1:0] r_bus_source;
   logic [SIZE*BUS_COUNT-1:0]               r_bus_value;
   logic [STATION_INDEX_SIZE-1:0]           r_ptr;

   logic [BUS_COUNT-1:0]                    w_bus_free;
   logic [STATION_COUNT-1:0]                w_grant;
   logic [STATION_INDEX_SIZE*BUS_COUNT-1:0] w_pick_source;
   logic [BUS_COUNT-1:0]                    w_taken;
   logic [STATION_INDEX_SIZE-1:0]           w_next_ptr;
   logic [SIZE*BUS_COUNT-1:0]               w_capture_value;

   // A bus is only unavailable when it carries a result its consumer stalls on.
   assign w_bus_free = ~(r_bus_asserted & bus_hold);

   rotating_priority_picker #(
      .STATION_COUNT      (STATION_COUNT),
      .BUS_COUNT          (BUS_COUNT),
      .STATION_INDEX_SIZE (STATION_INDEX_SIZE)
   ) u_picker (
      .i_request    (station_ready),
      .i_ptr        (r_ptr),
      .i_bus_free   (w_bus_free),
      .o_grant      (w_grant),
      .o_bus_source (w_pick_source),
      .o_bus_taken  (w_taken),
      .o_next_ptr   (w_next_ptr)
   );

   // Nothing is accepted while the buses are being reset or flushed.
   assign station_grant = (reset || flush) ? '0 : w_grant;

   // Select each taken bus's value from the granted station's slice.
   always_comb begin
      w_capture_value = '0;
      for (int j = 0; j < BUS_COUNT; j++) begin
         for (int i = 0; i < STATION_COUNT; i++) begin
            if (`RBS_SLICE(w_pick_source, j, STATION_INDEX_SIZE) == STATION_INDEX_SIZE'(i)) begin
               `RBS_SLICE(w_capture_value, j, SIZE) = `RBS_SLICE(station_value, i, SIZE);
            end else begin
               w_capture_value = w_capture_value;
            end
         end
      end
   end

   // Bus registers and priority pointer; reset outranks flush.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_bus_asserted <= '0;
         r_bus_source   <= '0;
         r_bus_value    <= '0;
         r_ptr          <= '0;
      end else if (flush) begin
         r_bus_asserted <= '0;
         r_bus_source   <= '0;
         r_bus_value    <= '0;
      end else begin
         for (int j = 0; j < BUS_COUNT; j++) begin
            if (w_taken[j]) begin
               r_bus_asserted[j]                               <= 1'b1;
               `RBS_SLICE(r_bus_source, j, STATION_INDEX_SIZE) <= `RBS_SLICE(w_pick_source, j, STATION_INDEX_SIZE);
               `RBS_SLICE(r_bus_value, j, SIZE)                <= `RBS_SLICE(w_capture_value, j, SIZE);
            end else if (w_bus_free[j]) begin
               r_bus_asserted[j]                               <= 1'b0;
               `RBS_SLICE(r_bus_source, j, STATION_INDEX_SIZE) <= '0;
               `RBS_SLICE(r_bus_value, j, SIZE)                <= '0;
            end
         end
         if (|w_grant) begin
            r_ptr <= w_next_ptr;
         end
      end
   end

   assign bus_asserted = r_bus_asserted;
   assign bus_source   = r_bus_source;
   assign bus_value    = r_bus_value;

endmodule

// File: tb/tb_result_bus_scheduler.sv
module tb_result_bus_scheduler;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clock = ~clock;

   // 4 stations, 2 buses
   logic         a_flush = 1'b0;
   logic [3:0]   a_ready = 4'd0;
   logic [127:0] a_value = 128'd0;
   logic [3:0]   a_grant;
   logic [1:0]   a_hold = 2'd0;
   logic [1:0]   a_asserted;
   logic [3:0]   a_source;
   logic [63:0]  a_bus_value;

   // 4 stations, 1 bus
   logic         s_flush = 1'b0;
   logic [3:0]   s_ready = 4'd0;
   logic [127:0] s_value = 128'd0;
   logic [3:0]   s_grant;
   logic [0:0]   s_hold = 1'b0;
   logic [0:0]   s_asserted;
   logic [1:0]   s_source;
   logic [31:0]  s_bus_value;

   // 3 stations, 2 buses
   logic         n_flush = 1'b0;
   logic [2:0]   n_ready = 3'd0;
   logic [95:0]  n_value = 96'd0;
   logic [2:0]   n_grant;
   logic [1:0]   n_hold = 2'd0;
   logic [1:0]   n_asserted;
   logic [3:0]   n_source;
   logic [63:0]  n_bus_value;

   result_bus_scheduler #(.SIZE(32), .STATION_COUNT(4), .BUS_COUNT(2)) dut_a (
      .clock(clock), .reset(reset), .flush(a_flush),
      .station_ready(a_ready), .station_value(a_value), .station_grant(a_grant),
      .bus_hold(a_hold), .bus_asserted(a_asserted), .bus_source(a_source), .bus_value(a_bus_value));

   result_bus_scheduler #(.SIZE(32), .STATION_COUNT(4), .BUS_COUNT(1)) dut_s (
      .clock(clock), .reset(reset), .flush(s_flush),
      .station_ready(s_ready), .station_value(s_value), .station_grant(s_grant),
      .bus_hold(s_hold), .bus_asserted(s_asserted), .bus_source(s_source), .bus_value(s_bus_value));

   result_bus_scheduler #(.SIZE(32), .STATION_COUNT(3), .BUS_COUNT(2)) dut_n (
      .clock(clock), .reset(reset), .flush(n_flush),
      .station_ready(n_ready), .station_value(n_value), .station_grant(n_grant),
      .bus_hold(n_hold), .bus_asserted(n_asserted), .bus_source(n_source), .bus_value(n_bus_value));

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      a_ready = 4'hF;
      a_value = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
      #1;
      n_checks++; if (a_grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant got=%b exp=0000", a_grant); end
      tick();
      tick();
      n_checks++; if ({a_asserted, a_source, a_bus_value} !== 70'd0) begin n_fail++; $display("FAIL reset_bus_a got=%h exp=0", {a_asserted, a_source, a_bus_value}); end
      n_checks++; if ({s_asserted, s_source, s_bus_value, n_asserted, n_source, n_bus_value} !== 105'd0) begin n_fail++; $display("FAIL reset_bus_sn got nonzero"); end
      reset   = 1'b0;
      a_ready = 4'b0000;
      #1;
      n_checks++; if (a_grant !== 4'b0000) begin n_fail++; $display("FAIL idle_grant got=%b exp=0000", a_grant); end
      tick();
      n_checks++; if ({a_asserted, a_source, a_bus_value} !== 70'd0) begin n_fail++; $display("FAIL idle_bus got=%h exp=0", {a_asserted, a_source, a_bus_value}); end
   endtask

   task automatic test_basic();
      a_ready = 4'hF;
      #1;
      n_checks++; if (a_grant !== 4'b0011) begin n_fail++; $display("FAIL basic_grant1 got=%b exp=0011", a_grant); end
      tick();
      n_checks++; if (a_asserted !== 2'b11) begin n_fail++; $display("FAIL basic_asserted1 got=%b exp=11", a_asserted); end
      n_checks++; if (a_source !== 4'b0100) begin n_fail++; $display("FAIL basic_source1 got=%b exp=0100", a_source); end
      n_checks++; if (a_bus_value !== {32'hA1, 32'hA0}) begin n_fail++; $display("FAIL basic_value1 got=%h", a_bus_value); end
      n_checks++; if (a_grant !== 4'b1100) begin n_fail++; $display("FAIL basic_grant2 got=%b exp=1100", a_grant); end
      tick();
      n_checks++; if (a_source !== 4'b1110) begin n_fail++; $display("FAIL basic_source2 got=%b exp=1110", a_source); end
      n_checks++; if (a_bus_value !== {32'hA3, 32'hA2}) begin n_fail++; $display("FAIL basic_value2 got=%h", a_bus_value); end
      n_checks++; if (a_grant !== 4'b0011) begin n_fail++; $display("FAIL basic_grant3 got=%b exp=0011", a_grant); end
      tick();
      n_checks++; if (a_source !== 4'b0100) begin n_fail++; $display("FAIL basic_source3 got=%b exp=0100", a_source); end
      a_ready = 4'b0000;
      #1;
      n_checks++; if (a_grant !== 4'b0000) begin n_fail++; $display("FAIL basic_nogrant got=%b exp=0000", a_grant); end
      tick();
      n_checks++; if ({a_asserted, a_source, a_bus_value} !== 70'd0) begin n_fail++; $display("FAIL basic_drain got=%h exp=0", {a_asserted, a_source, a_bus_value}); end
   endtask

   // pointer is 2 on entry
   task automatic test_hold();
      a_value = {32'hA3, 32'h55, 32'h11, 32'h10};
      a_ready = 4'b0100;
      #1;
      n_checks++; if (a_grant !== 4'b0100) begin n_fail++; $display("FAIL hold_setup_grant got=%b exp=0100", a_grant); end
      tick();
      n_checks++; if ({a_asserted, a_source} !== 6'b01_0010) begin n_fail++; $display("FAIL hold_setup_bus got=%b exp=010010", {a_asserted, a_source}); end
      a_hold  = 2'b01;
      a_ready = 4'b0011;
      #1;
      n_checks++; if (a_grant !== 4'b0001) begin n_fail++; $display("FAIL hold_grant got=%b exp=0001", a_grant); end
      tick();
      n_checks++; if ({a_asserted, a_source} !== 6'b11_0010) begin n_fail++; $display("FAIL hold_bus got=%b exp=110010", {a_asserted, a_source}); end
      n_checks++; if (a_bus_value !== {32'h10, 32'h55}) begin n_fail++; $display("FAIL hold_value got=%h", a_bus_value); end
      a_ready = 4'b0010;
      #1;
      n_checks++; if (a_grant !== 4'b0010) begin n_fail++; $display("FAIL hold_grant2 got=%b exp=0010", a_grant); end
      tick();
      n_checks++; if (a_source !== 4'b0110 || a_bus_value !== {32'h11, 32'h55}) begin n_fail++; $display("FAIL hold_bus2 got=%b/%h", a_source, a_bus_value); end
      a_hold  = 2'b00;
      a_ready = 4'b0000;
      tick();
      n_checks++; if (a_asserted !== 2'b00) begin n_fail++; $display("FAIL hold_release got=%b exp=00", a_asserted); end
      // hold on empty buses has no effect; pointer is 2 here
      a_hold  = 2'b11;
      a_ready = 4'b0001;
      #1;
      n_checks++; if (a_grant !== 4'b0001) begin n_fail++; $display("FAIL hold_empty_grant got=%b exp=0001", a_grant); end
      tick();
      n_checks++; if ({a_asserted, a_source, a_bus_value[31:0]} !== {2'b01, 4'b0000, 32'h10}) begin n_fail++; $display("FAIL hold_empty_bus got=%b", a_asserted); end
      a_hold  = 2'b00;
      a_ready = 4'b0000;
      tick();
   endtask

   // pointer is 1 on entry
   task automatic test_flush();
      a_value = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
      a_ready = 4'hF;
      #1;
      n_checks++; if (a_grant !== 4'b0110) begin n_fail++; $display("FAIL flush_setup_grant got=%b exp=0110", a_grant); end
      tick();
      n_checks++; if ({a_asserted, a_source} !== 6'b11_1001) begin n_fail++; $display("FAIL flush_setup_bus got=%b exp=111001", {a_asserted, a_source}); end
      a_hold  = 2'b11;
      a_flush = 1'b1;
      #1;
      n_checks++; if (a_grant !== 4'b0000) begin n_fail++; $display("FAIL flush_held_grant got=%b exp=0000", a_grant); end
      tick();
      n_checks++; if ({a_asserted, a_source, a_bus_value} !== 70'd0) begin n_fail++; $display("FAIL flush_held_bus got=%h exp=0", {a_asserted, a_source, a_bus_value}); end
      a_hold = 2'b00;
      #1;
      n_checks++; if (a_grant !== 4'b0000) begin n_fail++; $display("FAIL flush_free_grant got=%b exp=0000", a_grant); end
      tick();
      n_checks++; if (a_asserted !== 2'b00) begin n_fail++; $display("FAIL flush_free_bus got=%b exp=00", a_asserted); end
      a_flush = 1'b0;
      #1;
      n_checks++; if (a_grant !== 4'b1001) begin n_fail++; $display("FAIL flush_ptr_kept got=%b exp=1001", a_grant); end
      tick();
      n_checks++; if (a_source !== 4'b0011 || a_bus_value !== {32'hA0, 32'hA3}) begin n_fail++; $display("FAIL flush_after_bus got=%b/%h", a_source, a_bus_value); end
   endtask

   // buses hold (3,A3),(0,A0); pointer is 1
   task automatic test_all_held();
      a_hold = 2'b11;
      #1;
      n_checks++; if (a_grant !== 4'b0000) begin n_fail++; $display("FAIL allheld_grant got=%b exp=0000", a_grant); end
      tick();
      n_checks++; if ({a_asserted, a_source, a_bus_value} !== {2'b11, 4'b0011, 32'hA0, 32'hA3}) begin n_fail++; $display("FAIL allheld_keep got=%b/%h", a_source, a_bus_value); end
      a_hold = 2'b10;
      #1;
      n_checks++; if (a_grant !== 4'b0010) begin n_fail++; $display("FAIL partheld_grant got=%b exp=0010", a_grant); end
      tick();
      n_checks++; if ({a_asserted, a_source, a_bus_value} !== {2'b11, 4'b0001, 32'hA0, 32'hA1}) begin n_fail++; $display("FAIL partheld_bus got=%b/%h", a_source, a_bus_value); end
      a_hold  = 2'b00;
      a_ready = 4'b0000;
      tick();
   endtask

   // pointer is 2 on entry
   task automatic test_reset_mid();
      a_ready = 4'b0100;
      tick();
      a_ready = 4'hF;
      reset   = 1'b1;
      #1;
      n_checks++; if (a_grant !== 4'b0000) begin n_fail++; $display("FAIL rstmid_grant got=%b exp=0000", a_grant); end
      tick();
      n_checks++; if ({a_asserted, a_source, a_bus_value} !== 70'd0) begin n_fail++; $display("FAIL rstmid_bus got=%h exp=0", {a_asserted, a_source, a_bus_value}); end
      reset = 1'b0;
      #1;
      n_checks++; if (a_grant !== 4'b0011) begin n_fail++; $display("FAIL rstmid_ptr got=%b exp=0011", a_grant); end
      a_ready = 4'b0000;
      tick();
   endtask

   task automatic test_starvation();
      int    st3_grants;
      logic [3:0] exp_grant;
      st3_grants = 0;
      s_value = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
      s_ready = 4'hF;
      for (int c = 0; c < 8; c++) begin
         #1;
         exp_grant = 4'b0001 << (c % 4);
         n_checks++; if (s_grant !== exp_grant) begin n_fail++; $display("FAIL starve_grant c=%0d got=%b exp=%b", c, s_grant, exp_grant); end
         if (s_grant[3]) st3_grants++;
         tick();
         n_checks++; if ({s_asserted, s_source, s_bus_value} !== {1'b1, 2'(c % 4), 32'hD0 + 32'(c % 4)}) begin n_fail++; $display("FAIL starve_bus c=%0d got=%0d/%h", c, s_source, s_bus_value); end
      end
      n_checks++; if (st3_grants !== 2) begin n_fail++; $display("FAIL starve_count got=%0d exp=2", st3_grants); end
      s_ready = 4'b0000;
   endtask

   task automatic test_non_pow2();
      n_value = {32'hC2, 32'hC1, 32'hC0};
      n_ready = 3'b001;
      #1;
      n_checks++; if (n_grant !== 3'b001) begin n_fail++; $display("FAIL np2_grant1 got=%b exp=001", n_grant); end
      tick();
      n_ready = 3'b010;
      #1;
      n_checks++; if (n_grant !== 3'b010) begin n_fail++; $display("FAIL np2_grant2 got=%b exp=010", n_grant); end
      tick();
      n_ready = 3'b111;
      #1;
      n_checks++; if (n_grant !== 3'b101) begin n_fail++; $display("FAIL np2_wrap_grant got=%b exp=101", n_grant); end
      tick();
      n_checks++; if ({n_asserted, n_source, n_bus_value} !== {2'b11, 4'b0010, 32'hC0, 32'hC2}) begin n_fail++; $display("FAIL np2_wrap_bus got=%b/%h", n_source, n_bus_value); end
      n_checks++; if (n_grant !== 3'b110) begin n_fail++; $display("FAIL np2_ptr got=%b exp=110", n_grant); end
      tick();
      n_checks++; if ({n_asserted, n_source, n_bus_value} !== {2'b11, 4'b1001, 32'hC2, 32'hC1}) begin n_fail++; $display("FAIL np2_bus2 got=%b/%h", n_source, n_bus_value); end
      n_ready = 3'b000;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_flush();
      test_all_held();
      test_reset_mid();
      test_starvation();
      test_non_pow2();
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
